// File: rtl/dac_sample_fifo_feeder.sv
// Stereo sample FIFO between the tone/sample generator and the WM8731 codec.
// Frames {L,R} are buffered in a circular store. Frames are handed to the codec
// on its per-channel TRIG pulses. Playback waits until enough frames are primed,
// mutes and counts on underrun, then re-primes automatically.
module dac_sample_fifo_feeder #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned PRIME_LEVEL = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_LCHAN_DATA,
  input  logic [DATA_WIDTH-1:0] IN_RCHAN_DATA,
  input  logic                  DAC_LCHAN_TRIG,
  input  logic                  DAC_RCHAN_TRIG,
  output logic [DATA_WIDTH-1:0] DAC_LCHAN_DATA,
  output logic [DATA_WIDTH-1:0] DAC_RCHAN_DATA,
  output logic [DEPTH_LOG2:0]   FIFO_COUNT,
  output logic                  UNDERRUN,
  output logic [15:0]           UNDERRUN_COUNT,
  output logic                  PLAYING
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W   = DEPTH_LOG2 + 1;
  localparam int unsigned FRAME_W = 2 * DATA_WIDTH;
  localparam int unsigned UCNT_W  = 16;

  typedef enum logic [0:0] {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  logic [FRAME_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [FRAME_W-1:0]    rd_frame;
  logic [DATA_WIDTH-1:0] pend_r;

  logic fifo_full;
  logic fifo_empty;
  logic primed;
  logic push;
  logic pop;
  logic l_zero;
  logic underrun_evt;

  // Occupancy flags all derive from the registered count, so a frame pushed
  // into an empty FIFO cannot be popped in the same cycle.
  assign fifo_full  = (FIFO_COUNT == CNT_W'(DEPTH));
  assign fifo_empty = (FIFO_COUNT == '0);
  assign primed     = (FIFO_COUNT >= CNT_W'(PRIME_LEVEL));

  // Generator handshake; held low throughout reset.
  assign IN_READY = !RESET && !fifo_full;
  assign push     = IN_VALID && IN_READY;

  assign rd_frame = mem[rd_ptr];

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_PRIME;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: prime until the threshold, fall back to prime on underrun.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_PRIME: begin
        if (primed) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (DAC_LCHAN_TRIG && fifo_empty) begin
          next_state = ST_PRIME;
        end
      end
      default: next_state = ST_PRIME;
    endcase
  end

  // Per-state decode of the left-channel request into pop / mute / underrun.
  always_comb begin
    pop          = 1'b0;
    l_zero       = 1'b0;
    underrun_evt = 1'b0;
    unique case (state)
      ST_PRIME: begin
        l_zero = DAC_LCHAN_TRIG;
      end
      ST_RUN: begin
        if (DAC_LCHAN_TRIG) begin
          if (fifo_empty) begin
            l_zero       = 1'b1;
            underrun_evt = 1'b1;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: begin
        pop          = 1'b0;
        l_zero       = 1'b0;
        underrun_evt = 1'b0;
      end
    endcase
  end

  // Frame storage; contents need no reset since the pointers define validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {IN_LCHAN_DATA, IN_RCHAN_DATA};
    end
  end

  // Circular pointers wrap naturally at 2**DEPTH_LOG2.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
    end
  end

  // Registered occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      FIFO_COUNT <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   FIFO_COUNT <= FIFO_COUNT + CNT_W'(1);
        2'b01:   FIFO_COUNT <= FIFO_COUNT - CNT_W'(1);
        default: FIFO_COUNT <= FIFO_COUNT;
      endcase
    end
  end

  // Codec sample path; R always takes the pending value from before this edge's pop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      DAC_LCHAN_DATA <= '0;
      DAC_RCHAN_DATA <= '0;
      pend_r         <= '0;
    end else begin
      if (DAC_RCHAN_TRIG) begin
        DAC_RCHAN_DATA <= pend_r;
      end
      if (pop) begin
        DAC_LCHAN_DATA <= rd_frame[FRAME_W-1 -: DATA_WIDTH];
        pend_r         <= rd_frame[DATA_WIDTH-1:0];
      end else if (l_zero) begin
        DAC_LCHAN_DATA <= '0;
        pend_r         <= '0;
      end
    end
  end

  // Underrun pulse and saturating event counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      UNDERRUN       <= 1'b0;
      UNDERRUN_COUNT <= '0;
    end else begin
      UNDERRUN <= underrun_evt;
      if (underrun_evt && (UNDERRUN_COUNT != '1)) begin
        UNDERRUN_COUNT <= UNDERRUN_COUNT + UCNT_W'(1);
      end
    end
  end

  // Playback status, registered alongside the state so the two always agree.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PLAYING <= 1'b0;
    end else begin
      PLAYING <= (next_state == ST_RUN);
    end
  end

endmodule

// File: tb/tb_dac_sample_fifo_feeder.sv
// Randomised scoreboard bench for dac_sample_fifo_feeder. A queue-based
// reference model predicts each cycle's outputs; a negedge monitor compares.
module tb_dac_sample_fifo_feeder;

  logic        clk = 1'b0;
  logic        tb_rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_l;
  logic [15:0] in_r;
  logic        l_trig;
  logic        r_trig;
  logic [15:0] dac_l;
  logic [15:0] dac_r;
  logic [4:0]  fifo_count;
  logic        underrun;
  logic [15:0] underrun_count;
  logic        playing;

  always #5 clk = ~clk;

  dac_sample_fifo_feeder #(
    .DATA_WIDTH (16),
    .DEPTH_LOG2 (4),
    .PRIME_LEVEL(8)
  ) dut (
    .CLK           (clk),
    .RESET         (tb_rst),
    .IN_VALID      (in_valid),
    .IN_READY      (in_ready),
    .IN_LCHAN_DATA (in_l),
    .IN_RCHAN_DATA (in_r),
    .DAC_LCHAN_TRIG(l_trig),
    .DAC_RCHAN_TRIG(r_trig),
    .DAC_LCHAN_DATA(dac_l),
    .DAC_RCHAN_DATA(dac_r),
    .FIFO_COUNT    (fifo_count),
    .UNDERRUN      (underrun),
    .UNDERRUN_COUNT(underrun_count),
    .PLAYING       (playing)
  );

  typedef struct {
    logic [4:0]  cnt;
    logic        play;
    logic        und;
    logic [15:0] ucnt;
    logic [15:0] l;
    logic [15:0] r;
  } stat_t;

  stat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model state: stored frames as a plain queue of {L,R}.
  logic [31:0] m_q[$];
  bit          m_play = 1'b0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_l    = '0;
  logic [15:0] m_r    = '0;
  logic [15:0] m_ucnt = '0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: one expected output vector per clock edge.
  always @(negedge clk) begin
    stat_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("fifo_count", 32'(fifo_count), 32'(e.cnt));
      chk("playing", 32'(playing), 32'(e.play));
      chk("underrun", 32'(underrun), 32'(e.und));
      chk("underrun_count", 32'(underrun_count), 32'(e.ucnt));
      chk("dac_l", 32'(dac_l), 32'(e.l));
      chk("dac_r", 32'(dac_r), 32'(e.r));
      chk("in_ready", 32'(in_ready), 32'(!tb_rst && (e.cnt != 5'd16)));
    end
  end

  // Drive one cycle, advance the model, and queue the expected post-edge outputs.
  task automatic step(input bit rst, input bit vld, input bit lt, input bit rt,
                      input logic [15:0] l, input logic [15:0] r, output bit acc);
    bit          ready;
    bit          und;
    int          sz;
    logic [31:0] f;
    stat_t       e;
    tb_rst   = rst;
    in_valid = vld;
    l_trig   = lt;
    r_trig   = rt;
    in_l     = l;
    in_r     = r;
    ready = !rst && (m_q.size() != 16);
    acc   = vld && ready;
    und   = 1'b0;
    if (rst) begin
      m_q.delete();
      m_play = 1'b0;
      m_pend = '0;
      m_l    = '0;
      m_r    = '0;
      m_ucnt = '0;
    end else begin
      sz = m_q.size();
      if (rt) m_r = m_pend;
      if (lt) begin
        if (!m_play) begin
          m_l    = '0;
          m_pend = '0;
        end else if (sz > 0) begin
          f      = m_q.pop_front();
          m_l    = f[31:16];
          m_pend = f[15:0];
        end else begin
          m_l    = '0;
          m_pend = '0;
          und    = 1'b1;
          if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
        end
      end
      if (und) m_play = 1'b0;
      else if (!m_play && sz >= 8) m_play = 1'b1;
      if (acc) m_q.push_back({l, r});
    end
    e.cnt  = 5'(m_q.size());
    e.play = m_play;
    e.und  = und;
    e.ucnt = m_ucnt;
    e.l    = m_l;
    e.r    = m_r;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic cyc(input bit rst, input bit vld, input bit lt, input bit rt,
                     input logic [15:0] l, input logic [15:0] r);
    bit acc;
    step(rst, vld, lt, rt, l, r, acc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic prime(input int n, input logic [15:0] lb, input logic [15:0] rb);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, lb + 16'(i), rb + 16'(i));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          acc;
    int          k;
    int          guard;
    int          vprob;
    logic [15:0] gl;
    logic [15:0] gr;

    tb_rst = 1'b1; in_valid = 1'b0; l_trig = 1'b0; r_trig = 1'b0;
    in_l = '0; in_r = '0;

    // Reset, prime with 8 frames, first L and R requests.
    do_reset(2);
    prime(8, 16'h1000, 16'h2000);
    idle(2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    idle(1);

    // Fill to full with valid held high, no requests.
    do_reset(1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'(16'h5000 + i), 16'(16'h6000 + i));
    idle(2);

    // Drain past empty: 8 frames, then an underrun.
    do_reset(1);
    prime(8, 16'h1100, 16'h2100);
    idle(2);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    end
    idle(2);

    // Push and pop together at count 5, then stream in order through wrap.
    do_reset(1);
    prime(8, 16'h1200, 16'h2200);
    idle(2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h1AAA, 16'h2AAA);
    k = 0;
    guard = 0;
    while (k < 48 && guard < 600) begin
      step(1'b0, 1'b1, (guard % 2) == 1, (guard % 2) == 0,
           16'(16'h3000 + k), 16'(16'h4000 + k), acc);
      if (acc) k++;
      guard++;
    end
    if (k < 48) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stream_accept: got %0d frames accepted expected 48", k);
    end

    // Simultaneous L and R request, then R alone.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    idle(1);

    // Reset in the middle of a stream at count 10.
    do_reset(1);
    prime(12, 16'h1300, 16'h2300);
    idle(2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h7777, 16'h8888);
    idle(3);

    // Randomised traffic with alternating producer rates to provoke underruns.
    gl = 16'($urandom);
    gr = 16'($urandom);
    for (int i = 0; i < 2400; i++) begin
      vprob = ((i / 200) % 2 == 0) ? 80 : 20;
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < vprob),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           gl, gr, acc);
      if (acc) begin
        gl = 16'($urandom);
        gr = 16'($urandom);
      end
    end
    idle(1);

    #10;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
